// File: rtl/graphics_renderer_if.sv
// Pixel request / colour response bundle between the VGA timing side and the renderer.
// The master presents (x,y) with pixel_valid; the slave returns r,g,b with out_valid.
interface graphics_renderer_if #(
    parameter int X_W     = 10,
    parameter int Y_W     = 9,
    parameter int COLOR_W = 8
);
    logic               pixel_valid;
    logic [X_W-1:0]     x;
    logic [Y_W-1:0]     y;
    logic [COLOR_W-1:0] r;
    logic [COLOR_W-1:0] g;
    logic [COLOR_W-1:0] b;
    logic               out_valid;

    modport master (output pixel_valid, x, y, input r, g, b, out_valid);
    modport slave  (input pixel_valid, x, y, output r, g, b, out_valid);
endinterface

// File: rtl/graphics_renderer.sv
// Two-stage pixel renderer for meteor-dodge: frame-latched object state, score bar,
// meteors, ship and a blinking game-over overlay; one pixel per cycle, latency 2.
module graphics_renderer #(
    parameter int N_METEORS    = 6,
    parameter int X_W          = 10,
    parameter int Y_W          = 9,
    parameter int COLOR_W      = 8,
    parameter int H_ACTIVE     = 640,
    parameter int V_ACTIVE     = 480,
    parameter int SHIP_W       = 40,
    parameter int SHIP_H       = 15,
    parameter int METEOR_SIZE  = 30,
    parameter int BAR_H        = 8,
    parameter int BLINK_FRAMES = 30
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            frame_start,
    input  logic [X_W-1:0]                  ship_x,
    input  logic [Y_W-1:0]                  ship_y,
    input  logic [N_METEORS-1:0][X_W-1:0]   meteor_x,
    input  logic [N_METEORS-1:0][Y_W-1:0]   meteor_y,
    input  logic [N_METEORS-1:0]            meteor_active,
    input  logic [15:0]                     score,
    input  logic                            game_over,
    graphics_renderer_if.slave              pix
);

    localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [X_W:0]       SHIP_W_X = (X_W+1)'(SHIP_W);
    localparam logic [Y_W:0]       SHIP_H_Y = (Y_W+1)'(SHIP_H);
    localparam logic [X_W:0]       MET_X    = (X_W+1)'(METEOR_SIZE);
    localparam logic [Y_W:0]       MET_Y    = (Y_W+1)'(METEOR_SIZE);
    localparam logic [X_W:0]       H_ACT_X  = (X_W+1)'(H_ACTIVE);
    localparam logic [Y_W:0]       V_ACT_Y  = (Y_W+1)'(V_ACTIVE);
    localparam logic [Y_W:0]       BAR_H_Y  = (Y_W+1)'(BAR_H);
    localparam logic [15:0]        H_ACT_16 = 16'(H_ACTIVE);
    localparam logic [COLOR_W-1:0] C_MAX    = '1;
    localparam logic [COLOR_W-1:0] OVL_R    = COLOR_W'(3) << (COLOR_W - 3);
    localparam logic [CNT_W-1:0]   BLINK_LAST = CNT_W'(BLINK_FRAMES - 1);

    typedef enum logic {BLINK_OFF = 1'b0, BLINK_ON = 1'b1} blink_state_t;

    // Frame-latched object state
    logic [X_W-1:0]                sh_ship_x;
    logic [Y_W-1:0]                sh_ship_y;
    logic [N_METEORS-1:0][X_W-1:0] sh_met_x;
    logic [N_METEORS-1:0][Y_W-1:0] sh_met_y;
    logic [N_METEORS-1:0]          sh_met_act;
    logic [15:0]                   sh_score;
    logic                          sh_go;
    logic [CNT_W-1:0]              blink_cnt;
    blink_state_t                  blink_state;

    // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values
    // regardless of block evaluation order; blocking here would create simulation races.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh_ship_x   <= '0;
            sh_ship_y   <= '0;
            sh_met_x    <= '0;
            sh_met_y    <= '0;
            sh_met_act  <= '0;
            sh_score    <= '0;
            sh_go       <= 1'b0;
            blink_cnt   <= '0;
            blink_state <= BLINK_ON;
        end else if (frame_start) begin
            sh_ship_x  <= ship_x;
            sh_ship_y  <= ship_y;
            sh_met_x   <= meteor_x;
            sh_met_y   <= meteor_y;
            sh_met_act <= meteor_active;
            sh_score   <= score;
            sh_go      <= game_over;
            // The frame in which game-over first latches is the first ON frame, so
            // counting starts only once it was already set on the previous frame.
            if (!game_over || !sh_go) begin
                blink_cnt   <= '0;
                blink_state <= BLINK_ON;
            end else if (blink_cnt == BLINK_LAST) begin
                blink_cnt   <= '0;
                blink_state <= (blink_state == BLINK_ON) ? BLINK_OFF : BLINK_ON;
            end else begin
                blink_cnt <= blink_cnt + CNT_W'(1);
            end
        end
    end

    // Stage 1: hit tests against shadow state, sums one bit wider so nothing wraps
    logic [X_W:0] px_w;
    logic [Y_W:0] py_w;
    logic [15:0]  bar_len;
    logic         hit_ship_c, hit_met_c, hit_bar_c;

    assign px_w = {1'b0, pix.x};
    assign py_w = {1'b0, pix.y};

    // NOTE: every always_comb output gets a default before any branch, otherwise an
    // unassigned path infers a latch.
    always_comb begin
        hit_met_c = 1'b0;
        bar_len   = sh_score >> 4;
        if (bar_len > H_ACT_16)
            bar_len = H_ACT_16;
        hit_bar_c  = (py_w < BAR_H_Y) && (16'(pix.x) < bar_len);
        hit_ship_c = (px_w >= {1'b0, sh_ship_x}) && (px_w < {1'b0, sh_ship_x} + SHIP_W_X) &&
                     (py_w >= {1'b0, sh_ship_y}) && (py_w < {1'b0, sh_ship_y} + SHIP_H_Y);
        for (int i = 0; i < N_METEORS; i++) begin
            if (sh_met_act[i] &&
                ({1'b0, sh_met_x[i]} < H_ACT_X) && ({1'b0, sh_met_y[i]} < V_ACT_Y) &&
                (px_w >= {1'b0, sh_met_x[i]}) && (px_w < {1'b0, sh_met_x[i]} + MET_X) &&
                (py_w >= {1'b0, sh_met_y[i]}) && (py_w < {1'b0, sh_met_y[i]} + MET_Y))
                hit_met_c = 1'b1;
        end
    end

    logic v1, hit_ship1, hit_met1, hit_bar1, ovl1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v1        <= 1'b0;
            hit_ship1 <= 1'b0;
            hit_met1  <= 1'b0;
            hit_bar1  <= 1'b0;
            ovl1      <= 1'b0;
        end else begin
            v1        <= pix.pixel_valid;
            hit_ship1 <= hit_ship_c;
            hit_met1  <= hit_met_c;
            hit_bar1  <= hit_bar_c;
            // 16x16 checkerboard, gated by the overlay state seen by this pixel
            ovl1      <= sh_go && (blink_state == BLINK_ON) && (pix.x[4] ^ pix.y[4]);
        end
    end

    // Stage 2: priority colour, overlay tint, registered output
    logic [COLOR_W-1:0] r_n, g_n, b_n;

    always_comb begin
        r_n = '0;
        g_n = '0;
        b_n = '0;
        if (v1) begin
            if (hit_bar1) begin
                g_n = C_MAX;
            end else if (hit_met1) begin
                r_n = C_MAX;
            end else if (hit_ship1) begin
                r_n = C_MAX;
                g_n = C_MAX;
                b_n = C_MAX;
            end
            if (ovl1) begin
                r_n = r_n | OVL_R;
                g_n = g_n >> 1;
                b_n = b_n >> 1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pix.out_valid <= 1'b0;
            pix.r         <= '0;
            pix.g         <= '0;
            pix.b         <= '0;
        end else begin
            pix.out_valid <= v1;
            pix.r         <= r_n;
            pix.g         <= g_n;
            pix.b         <= b_n;
        end
    end

endmodule

// File: tb/tb_graphics_renderer.sv
// Scoreboard bench for graphics_renderer: directed scenarios plus random frames checked
// against a rectangle/priority reference model of the renderer's drawing rules.
module tb_graphics_renderer;

    localparam int N  = 6;
    localparam int XW = 10;
    localparam int YW = 9;
    localparam int CW = 8;
    localparam int BF = 2;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   frame_start;
    logic [XW-1:0]          ship_x;
    logic [YW-1:0]          ship_y;
    logic [N-1:0][XW-1:0]   meteor_x;
    logic [N-1:0][YW-1:0]   meteor_y;
    logic [N-1:0]           meteor_active;
    logic [15:0]            score;
    logic                   game_over;

    graphics_renderer_if #(.X_W(XW), .Y_W(YW), .COLOR_W(CW)) pix ();

    graphics_renderer #(
        .N_METEORS(N), .X_W(XW), .Y_W(YW), .COLOR_W(CW), .H_ACTIVE(640), .V_ACTIVE(480),
        .SHIP_W(40), .SHIP_H(15), .METEOR_SIZE(30), .BAR_H(8), .BLINK_FRAMES(BF)
    ) dut (
        .clk(clk), .reset(reset), .frame_start(frame_start),
        .ship_x(ship_x), .ship_y(ship_y), .meteor_x(meteor_x), .meteor_y(meteor_y),
        .meteor_active(meteor_active), .score(score), .game_over(game_over), .pix(pix)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference model: what the screen should show this frame
    int m_ship_x, m_ship_y, m_score, m_go_frames;
    int m_mx [N];
    int m_my [N];
    bit m_act [N];
    bit m_go;

    task automatic model_reset();
        m_ship_x = 0; m_ship_y = 0; m_score = 0; m_go = 0; m_go_frames = 0;
        for (int i = 0; i < N; i++) begin
            m_mx[i] = 0; m_my[i] = 0; m_act[i] = 0;
        end
    endtask

    task automatic model_frame();
        m_ship_x = ship_x; m_ship_y = ship_y; m_score = score;
        for (int i = 0; i < N; i++) begin
            m_mx[i] = meteor_x[i]; m_my[i] = meteor_y[i]; m_act[i] = meteor_active[i];
        end
        if (game_over) m_go_frames = m_go ? m_go_frames + 1 : 1;
        else           m_go_frames = 0;
        m_go = game_over;
    endtask

    function automatic logic [23:0] model_rgb(input int px, input int py);
        int  r, g, b, bar_len;
        bit  in_bar, in_met, in_ship, overlay;
        bar_len = (m_score / 16 < 640) ? m_score / 16 : 640;
        in_bar  = (py < 8) && (px < bar_len);
        in_ship = (px >= m_ship_x) && (px < m_ship_x + 40) && (py >= m_ship_y) && (py < m_ship_y + 15);
        in_met  = 0;
        for (int i = 0; i < N; i++)
            if (m_act[i] && m_mx[i] < 640 && m_my[i] < 480 &&
                px >= m_mx[i] && px < m_mx[i] + 30 && py >= m_my[i] && py < m_my[i] + 30)
                in_met = 1;
        r = 0; g = 0; b = 0;
        if (in_bar)       g = 255;
        else if (in_met)  r = 255;
        else if (in_ship) begin r = 255; g = 255; b = 255; end
        overlay = m_go && (((m_go_frames - 1) / BF) % 2 == 0) && (((px / 16) + (py / 16)) % 2 == 1);
        if (overlay) begin
            r = r | 8'h60; g = g / 2; b = b / 2;
        end
        return {r[7:0], g[7:0], b[7:0]};
    endfunction

    typedef struct {
        int          x;
        int          y;
        logic [23:0] rgb;
        int          due;
    } exp_t;
    exp_t sb [$];

    task automatic drive(input bit pv, input int px, input int py, input bit fs,
                         input bit use_exp = 1'b0, input logic [23:0] exp_rgb = '0);
        logic [23:0] e;
        @(negedge clk);
        pix.pixel_valid = pv;
        pix.x           = px[XW-1:0];
        pix.y           = py[YW-1:0];
        frame_start     = fs;
        if (pv) begin
            e = use_exp ? exp_rgb : model_rgb(px, py);
            sb.push_back('{x: px, y: py, rgb: e, due: cyc + 2});
        end
        if (fs) model_frame();
    endtask

    // Monitor: pop and compare whenever the DUT presents a pixel
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (pix.out_valid) begin
                    if (sb.size() == 0) begin
                        check("unexpected out_valid", 32'd1, 32'd0);
                    end else begin
                        e = sb.pop_front();
                        check($sformatf("rgb x=%0d y=%0d", e.x, e.y),
                              {8'h0, pix.r, pix.g, pix.b}, {8'h0, e.rgb});
                        check($sformatf("latency x=%0d y=%0d", e.x, e.y), cyc, e.due);
                    end
                end else begin
                    check("rgb while idle", {8'h0, pix.r, pix.g, pix.b}, 32'd0);
                end
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic pick_pixel(output int px, output int py);
        int k;
        case ($urandom_range(0, 3))
            0: begin px = $urandom_range(0, 1023); py = $urandom_range(0, 511); end
            1: begin px = m_ship_x + $urandom_range(0, 44) - 2; py = m_ship_y + $urandom_range(0, 19) - 2; end
            2: begin
                k  = $urandom_range(0, N - 1);
                px = m_mx[k] + $urandom_range(0, 34) - 2; py = m_my[k] + $urandom_range(0, 34) - 2;
            end
            default: begin px = $urandom_range(0, 1023); py = $urandom_range(0, 10); end
        endcase
        px = px & 1023;
        py = py & 511;
    endtask

    task automatic randomize_game();
        ship_x = ($urandom_range(0, 4) == 0) ? XW'($urandom_range(960, 1023)) : XW'($urandom_range(0, 1023));
        ship_y = YW'($urandom_range(0, 511));
        for (int i = 0; i < N; i++) begin
            meteor_x[i]      = XW'($urandom_range(0, 1023));
            meteor_y[i]      = YW'($urandom_range(0, 511));
            meteor_active[i] = 1'($urandom_range(0, 1));
        end
        score = 16'($urandom_range(0, 65535));
        if ($urandom_range(0, 3) == 0) game_over = ~game_over;
    endtask

    initial begin
        int px, py;
        reset = 1'b0; frame_start = 1'b0; game_over = 1'b0; score = '0;
        ship_x = '0; ship_y = '0; meteor_x = '0; meteor_y = '0; meteor_active = '0;
        pix.pixel_valid = 1'b0; pix.x = '0; pix.y = '0;
        model_reset();
        #1 reset = 1'b1;
        #2;
        check("reset out_valid", {31'd0, pix.out_valid}, 32'd0);
        check("reset rgb", {8'h0, pix.r, pix.g, pix.b}, 32'd0);
        @(negedge clk);
        #2 reset = 1'b0;

        // Ship only
        ship_x = 10'd100; ship_y = 9'd200;
        drive(0, 0, 0, 1);
        drive(1, 100, 200, 0, 1, 24'hFFFFFF);
        drive(1, 140, 200, 0, 1, 24'h000000);
        drive(1, 139, 214, 0, 1, 24'hFFFFFF);

        // Meteor over ship wins; off-screen meteor never drawn
        meteor_x[0] = 10'd120; meteor_y[0] = 9'd190; meteor_active[0] = 1'b1;
        drive(0, 0, 0, 1);
        drive(1, 125, 205, 0, 1, 24'hFF0000);
        meteor_x[0] = 10'd650;
        drive(0, 0, 0, 1);
        drive(1, 650, 200, 0, 1, 24'h000000);
        drive(1, 125, 205, 0, 1, 24'hFFFFFF);

        // Mid-frame change is invisible until the next frame_start
        ship_x = 10'd300;
        drive(1, 100, 200, 0, 1, 24'hFFFFFF);
        drive(0, 0, 0, 1);
        drive(1, 100, 200, 0, 1, 24'h000000);
        drive(1, 300, 200, 0, 1, 24'hFFFFFF);

        // Score bar
        score = 16'd1600;
        drive(0, 0, 0, 1);
        drive(1, 99, 0, 0, 1, 24'h00FF00);
        drive(1, 100, 0, 0, 1, 24'h000000);
        score = 16'hFFFF;
        drive(0, 0, 0, 1);
        drive(1, 639, 0, 0, 1, 24'h00FF00);
        drive(1, 640, 0, 0, 1, 24'h000000);
        // Pixel alongside frame_start uses the old shadows
        score = 16'd0;
        drive(1, 639, 7, 1, 1, 24'h00FF00);
        drive(1, 639, 7, 0, 1, 24'h000000);

        // Objects near max coordinate clip instead of wrapping
        ship_x = 10'd1000; ship_y = 9'd500;
        drive(0, 0, 0, 1);
        drive(1, 1020, 505, 0, 1, 24'hFFFFFF);
        drive(1, 3, 505, 0, 1, 24'h000000);
        drive(1, 1020, 2, 0, 1, 24'h000000);

        // Game-over blink, two frames per phase
        game_over = 1'b1;
        for (int f = 1; f <= 4; f++) begin
            drive(0, 0, 0, 1);
            drive(1, 16, 0, 0, 1, (f <= 2) ? 24'h600000 : 24'h000000);
            drive(1, 0, 0, 0, 1, 24'h000000);
        end
        drive(0, 0, 0, 1);
        drive(1, 16, 0, 0, 1, 24'h600000);
        game_over = 1'b0;
        drive(0, 0, 0, 1);
        drive(1, 16, 0, 0, 1, 24'h000000);

        // Reset while streaming
        ship_x = 10'd100; ship_y = 9'd200;
        drive(0, 0, 0, 1);
        for (int i = 0; i < 6; i++) drive(1, 100 + i, 200, 0, 1, 24'hFFFFFF);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("mid-stream reset out_valid", {31'd0, pix.out_valid}, 32'd0);
        check("mid-stream reset rgb", {8'h0, pix.r, pix.g, pix.b}, 32'd0);
        sb.delete();
        model_reset();
        pix.pixel_valid = 1'b0;
        frame_start     = 1'b0;
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
        drive(1, 5, 5, 0, 1, 24'hFFFFFF);
        drive(1, 50, 5, 0, 1, 24'h000000);

        // Random frames
        for (int f = 0; f < 40; f++) begin
            randomize_game();
            pick_pixel(px, py);
            drive(1'($urandom_range(0, 1)), px, py, 1);
            for (int p = 0; p < 120; p++) begin
                if (p == 60) begin
                    ship_x = XW'($urandom_range(0, 1023));
                    score  = 16'($urandom_range(0, 65535));
                end
                pick_pixel(px, py);
                drive(1'($urandom_range(0, 7) != 0), px, py, 0);
            end
        end

        repeat (4) drive(0, 0, 0, 0);
        check("scoreboard drained", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
